pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage miniLA pipeline.
- Takes the load-use request from the ID-stage data-hazard detector, taken-branch redirects from EX, and the MEM-stage data-RAM handshake.
- Tracks one outstanding multi-cycle MDU (mul/div) write in a register scoreboard.
- Drives every pipeline-register stop/flush with a fixed priority, and keeps stall and flush statistics counters.

---
 rtl/pipeline_hazard_ctrl_if.sv | 44 ++++
 rtl/pipeline_hazard_ctrl.sv | 110 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the miniLA pipeline (master) and the stall/flush sequencer (slave).
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             load_use;
  logic [4:0]       id_rj;
  logic [4:0]       id_r2;
  logic             id_read1;
  logic             id_read2;
  logic [4:0]       id_wreg;
  logic             id_wena;
  logic             id_is_mdu;
  logic             ex_mdu_issue;
  logic [4:0]       ex_mdu_dst;
  logic             mdu_done;
  logic             ex_br_taken;
  logic             mem_req;
  logic             mem_ack;
  logic             PC_stop;
  logic             IFID_stop;
  logic             IDEX_stop;
  logic             EXMEM_stop;
  logic             IFID_flush;
  logic             IDEX_flush;
  logic             MEMWB_flush;
  logic             mem_err;
  logic [31:0]      sb_busy;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output load_use, id_rj, id_r2, id_read1, id_read2, id_wreg, id_wena, id_is_mdu,
           ex_mdu_issue, ex_mdu_dst, mdu_done, ex_br_taken, mem_req, mem_ack,
    input  PC_stop, IFID_stop, IDEX_stop, EXMEM_stop, IFID_flush, IDEX_flush, MEMWB_flush,
           mem_err, sb_busy, stall_cnt, flush_cnt
  );

  modport slave (
    input  load_use, id_rj, id_r2, id_read1, id_read2, id_wreg, id_wena, id_is_mdu,
           ex_mdu_issue, ex_mdu_dst, mdu_done, ex_br_taken, mem_req, mem_ack,
    output PC_stop, IFID_stop, IDEX_stop, EXMEM_stop, IFID_flush, IDEX_flush, MEMWB_flush,
           mem_err, sb_busy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage miniLA pipeline with one-entry MDU scoreboard.
// Stop/flush outputs are same-cycle combinational; a DRAM wait freezes everything, bounded by MEM_TIMEOUT.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input logic                   cpu_clk,
  input logic                   cpu_rstn,
  pipeline_hazard_ctrl_if.slave hz
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, MEM_ERR} state_t;

  state_t           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [31:0]      sb_busy_q, sb_busy_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic freeze, sb_hit, id_stall, eff_issue;
  logic pc_stop, ifid_stop, idex_stop, exmem_stop;
  logic ifid_flush, idex_flush, memwb_flush;

  always_comb begin
    // An ack arriving while waiting releases the pipeline in the same cycle.
    freeze = ((state_q == RUN) && hz.mem_req && !hz.mem_ack) ||
             ((state_q == MEM_WAIT) && !hz.mem_ack);
    sb_hit = (hz.id_read1 && sb_busy_q[hz.id_rj]) ||
             (hz.id_read2 && sb_busy_q[hz.id_r2]) ||
             (hz.id_wena && sb_busy_q[hz.id_wreg]) ||
             (hz.id_is_mdu && (|sb_busy_q));
    id_stall  = hz.load_use || sb_hit;
    eff_issue = hz.ex_mdu_issue && !freeze && (hz.ex_mdu_dst != 5'd0);

    pc_stop     = 1'b0;
    ifid_stop   = 1'b0;
    idex_stop   = 1'b0;
    exmem_stop  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    if (!cpu_rstn) begin
      pc_stop = 1'b0;
    end else if (freeze) begin
      pc_stop     = 1'b1;
      ifid_stop   = 1'b1;
      idex_stop   = 1'b1;
      exmem_stop  = 1'b1;
      memwb_flush = 1'b1;
    end else if (hz.ex_br_taken) begin
      // The ID instruction is wrong-path, so a pending ID stall is moot.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (id_stall) begin
      pc_stop    = 1'b1;
      ifid_stop  = 1'b1;
      idex_flush = 1'b1;
    end

    state_d    = state_q;
    wait_cnt_d = '0;
    case (state_q)
      RUN:      if (hz.mem_req && !hz.mem_ack) state_d = MEM_WAIT;
      MEM_WAIT: begin
        if (hz.mem_ack)                               state_d = RUN;
        else if (wait_cnt_q == 8'(MEM_TIMEOUT - 1))   state_d = MEM_ERR;
        else                                          wait_cnt_d = wait_cnt_q + 8'd1;
      end
      default:  state_d = RUN;
    endcase
    mem_err_d = (state_d == MEM_ERR);

    // Only one MDU write is ever outstanding, so done clears the whole vector before a new set.
    sb_busy_d = hz.mdu_done ? 32'd0 : sb_busy_q;
    if (eff_issue) sb_busy_d[hz.ex_mdu_dst] = 1'b1;

    stall_cnt_d = stall_cnt_q + CNT_W'(pc_stop);
    flush_cnt_d = flush_cnt_q + CNT_W'(ifid_flush);
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      sb_busy_q   <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      sb_busy_q   <= sb_busy_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.PC_stop     = pc_stop;
  assign hz.IFID_stop   = ifid_stop;
  assign hz.IDEX_stop   = idex_stop;
  assign hz.EXMEM_stop  = exmem_stop;
  assign hz.IFID_flush  = ifid_flush;
  assign hz.IDEX_flush  = idex_flush;
  assign hz.MEMWB_flush = memwb_flush;
  assign hz.mem_err     = mem_err_q;
  assign hz.sb_busy     = sb_busy_q;
  assign hz.stall_cnt   = stall_cnt_q;
  assign hz.flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed test-plan steps followed by random traffic, all checked against a cycle-level rule model.
module tb_pipeline_hazard_ctrl;
  localparam int TO = 4;
  localparam int CW = 8;

  typedef struct packed {
    logic       lu, rd1, rd2, wena, ismdu, iss, done, br, req, ack;
    logic [4:0] rj, r2, wreg, dst;
  } stim_t;

  logic cpu_clk = 1'b0;
  logic cpu_rstn = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CW)) hz ();

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .cpu_clk  (cpu_clk),
    .cpu_rstn (cpu_rstn),
    .hz       (hz)
  );

  int errors = 0;
  int checks = 0;

  // Model: memory mode (0 running, 1 waiting, 2 timed out), waited cycles, pending MDU reg (-1 none).
  int m_mode = 0;
  int m_waited = 0;
  int m_pend = -1;
  int m_stall = 0;
  int m_flush = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {hz.PC_stop, hz.IFID_stop, hz.IDEX_stop, hz.EXMEM_stop,
            hz.IFID_flush, hz.IDEX_flush, hz.MEMWB_flush};
  endfunction

  task automatic drive(input stim_t s);
    hz.load_use     = s.lu;
    hz.id_read1     = s.rd1;
    hz.id_read2     = s.rd2;
    hz.id_wena      = s.wena;
    hz.id_is_mdu    = s.ismdu;
    hz.ex_mdu_issue = s.iss;
    hz.mdu_done     = s.done;
    hz.ex_br_taken  = s.br;
    hz.mem_req      = s.req;
    hz.mem_ack      = s.ack;
    hz.id_rj        = s.rj;
    hz.id_r2        = s.r2;
    hz.id_wreg      = s.wreg;
    hz.ex_mdu_dst   = s.dst;
  endtask

  function automatic logic [31:0] exp_sb();
    return (m_pend < 0) ? 32'd0 : (32'd1 << m_pend);
  endfunction

  task automatic check_regs(input string tag);
    check({tag, ".sb"}, hz.sb_busy, exp_sb());
    check({tag, ".stall_cnt"}, 32'(hz.stall_cnt), 32'(m_stall));
    check({tag, ".flush_cnt"}, 32'(hz.flush_cnt), 32'(m_flush));
    check({tag, ".mem_err"}, 32'(hz.mem_err), 32'(m_mode == 2));
  endtask

  // One clock: drive at negedge, check same-cycle outputs, advance model, check registered state.
  task automatic cycle(input stim_t s, input string tag);
    bit frz, hit;
    logic [6:0] e;
    drive(s);
    #1;
    frz = (m_mode == 0 && s.req && !s.ack) || (m_mode == 1 && !s.ack);
    hit = (m_pend >= 0) && ((s.rd1 && int'(s.rj) == m_pend) || (s.rd2 && int'(s.r2) == m_pend) ||
                            (s.wena && int'(s.wreg) == m_pend) || s.ismdu);
    if (frz)                 e = 7'b1111_001;
    else if (s.br)           e = 7'b0000_110;
    else if (s.lu || hit)    e = 7'b1100_010;
    else                     e = 7'b0000_000;
    check({tag, ".outs"}, 32'(outs()), 32'(e));
    @(posedge cpu_clk);
    m_stall = (m_stall + int'(e[6])) % (1 << CW);
    m_flush = (m_flush + int'(e[2])) % (1 << CW);
    if (s.done) m_pend = -1;
    if (s.iss && !frz && s.dst != 5'd0) m_pend = int'(s.dst);
    if (m_mode == 0) begin
      if (s.req && !s.ack) begin m_mode = 1; m_waited = 0; end
    end else if (m_mode == 1) begin
      if (s.ack) m_mode = 0;
      else begin
        m_waited++;
        if (m_waited == TO) m_mode = 2;
      end
    end else begin
      m_mode = 0;
    end
    #1;
    check_regs(tag);
    @(negedge cpu_clk);
  endtask

  task automatic model_reset();
    m_mode = 0; m_waited = 0; m_pend = -1; m_stall = 0; m_flush = 0;
  endtask

  initial begin
    stim_t s;
    logic [5:0] err_seen;

    s = '0;
    drive(s);
    #1;
    check("rst.outs", 32'(outs()), 32'd0);
    check_regs("rst");
    @(negedge cpu_clk);
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;

    s = '0; s.lu = 1'b1;
    cycle(s, "load_use");
    check("load_use.cnt", 32'(hz.stall_cnt), 32'd1);
    s = '0;
    cycle(s, "idle");

    s = '0; s.iss = 1'b1; s.dst = 5'd5;
    cycle(s, "raw.issue");
    check("raw.sb20", hz.sb_busy, 32'h20);
    s = '0; s.rd1 = 1'b1; s.rj = 5'd5;
    for (int i = 0; i < 3; i++) cycle(s, "raw.wait");
    s.done = 1'b1;
    cycle(s, "raw.done");
    check("raw.sb_clr", hz.sb_busy, 32'd0);
    s.done = 1'b0;
    cycle(s, "raw.free");

    s = '0; s.br = 1'b1; s.lu = 1'b1;
    cycle(s, "br_vs_stall");

    s = '0; s.br = 1'b1; s.req = 1'b1;
    for (int i = 0; i < 3; i++) cycle(s, "memwait");
    s.ack = 1'b1;
    cycle(s, "memwait.ack");
    check("memwait.ackflush", 32'(m_mode), 32'd0);

    s = '0; s.req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle(s, "timeout");
      err_seen[i] = hz.mem_err;
    end
    check("timeout.pulse", 32'(err_seen), 32'h10);
    s = '0;
    for (int i = 0; i < 2; i++) cycle(s, "timeout.idle");

    s = '0; s.iss = 1'b1; s.dst = 5'd3;
    cycle(s, "sb.r3");
    s.done = 1'b1; s.dst = 5'd7;
    cycle(s, "sb.swap");
    check("sb.r7", hz.sb_busy, 32'h80);
    s = '0; s.done = 1'b1;
    cycle(s, "sb.done");
    s = '0; s.iss = 1'b1; s.dst = 5'd0;
    cycle(s, "sb.r0");
    check("sb.r0_zero", hz.sb_busy, 32'd0);

    s = '0; s.iss = 1'b1; s.dst = 5'd9;
    cycle(s, "rstwait.issue");
    s = '0; s.req = 1'b1;
    cycle(s, "rstwait.req");
    cpu_rstn = 1'b0;
    #1;
    model_reset();
    check("rstwait.outs", 32'(outs()), 32'd0);
    check_regs("rstwait");
    s = '0;
    drive(s);
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;

    for (int i = 0; i < 500; i++) begin
      s = '0;
      s.lu    = ($urandom_range(0, 7) == 0);
      s.rd1   = 1'($urandom_range(0, 1));
      s.rd2   = 1'($urandom_range(0, 1));
      s.wena  = 1'($urandom_range(0, 1));
      s.ismdu = ($urandom_range(0, 5) == 0);
      s.rj    = (m_pend >= 0 && $urandom_range(0, 2) == 0) ? 5'(m_pend) : 5'($urandom_range(0, 31));
      s.r2    = (m_pend >= 0 && $urandom_range(0, 2) == 0) ? 5'(m_pend) : 5'($urandom_range(0, 31));
      s.wreg  = (m_pend >= 0 && $urandom_range(0, 3) == 0) ? 5'(m_pend) : 5'($urandom_range(0, 31));
      s.done  = (m_pend >= 0) && ($urandom_range(0, 3) == 0);
      s.iss   = (m_pend < 0 || s.done) && ($urandom_range(0, 2) == 0);
      s.dst   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      s.br    = ($urandom_range(0, 4) == 0);
      s.req   = (m_mode == 1) || ($urandom_range(0, 5) == 0);
      s.ack   = ($urandom_range(0, 2) == 0);
      cycle(s, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
